// File: rtl/draw_pkg.sv
// draw_pkg: shared screen geometry, frame-buffer address width and point-writer FSM states.
package draw_pkg;
    localparam logic [9:0] X_MAX = 10'd799;
    localparam logic [9:0] Y_MAX = 10'd599;
    localparam int LINE_WIDTH = 800;
    localparam int ADDR_W = 20;
    typedef enum logic [2:0] {IDLE, LOAD, STAMP, RENEW, SETTLE, FIN} state_t;
endpackage

// File: rtl/line_point_writer_if.sv
// line_point_writer_if: frame-buffer write port; the writer is master, the frame buffer is slave.
interface line_point_writer_if;
    logic                        o_wr_req;
    logic [draw_pkg::ADDR_W-1:0] o_wr_addr;
    logic [15:0]                 o_wr_data;
    logic                        i_wr_ack;
    modport master (output o_wr_req, o_wr_addr, o_wr_data, input i_wr_ack);
    modport slave (input o_wr_req, o_wr_addr, o_wr_data, output i_wr_ack);
endinterface

// File: rtl/pixel_addr_calc.sv
// pixel_addr_calc: combinational y*800+x using shifts only (800 = 512+256+32).
module pixel_addr_calc (
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [19:0] addr
);
    always_comb addr = {1'b0, y, 9'd0} + {2'd0, y, 8'd0} + {5'd0, y, 5'd0} + {10'd0, x};
endmodule

// File: rtl/line_point_writer.sv
// line_point_writer: stamps a square (or, with POINT_ROUND_EN, corner-less) point at each generator position.
module line_point_writer #(
    parameter logic [9:0] X_MAX = draw_pkg::X_MAX,
    parameter logic [9:0] Y_MAX = draw_pkg::Y_MAX,
    parameter int LINE_WIDTH = draw_pkg::LINE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [9:0]                 i_X_pos,
    input  logic [9:0]                 i_Y_pos,
    input  logic                       i_done,
    input  logic [3:0]                 point_size,
    input  logic [15:0]                color,
    output logic                       o_renew,
    output logic                       o_busy,
    output logic                       o_frame_done,
    line_point_writer_if.master        bus
);
    draw_pkg::state_t state;
    logic [9:0]  x, y;
    logic [3:0]  ps, dx, dy, ndx, ndy;
    logic [10:0] sx, sy;
    logic [19:0] addr;
    logic        load, last, advance, corner, visible;
    // Next stamp position is precomputed so request/address can be registered.
    always_comb begin
        load    = state == draw_pkg::LOAD;
        last    = dx == ps && dy == ps;
        advance = !bus.o_wr_req || bus.i_wr_ack;
        ndx     = (load || dx == ps) ? 4'd0 : dx + 4'd1;
        ndy     = load ? 4'd0 : (dx == ps) ? dy + 4'd1 : dy;
        sx      = {1'b0, load ? i_X_pos : x} + {7'd0, ndx};
        sy      = {1'b0, load ? i_Y_pos : y} + {7'd0, ndy};
        visible = sx <= {1'b0, X_MAX} && sy <= {1'b0, Y_MAX} && !corner;
    end
`ifdef POINT_ROUND_EN
    logic [3:0] psz;
    always_comb begin
        psz    = load ? point_size : ps;
        corner = psz >= 4'd2 && (ndx == 4'd0 || ndx == psz) && (ndy == 4'd0 || ndy == psz);
    end
`else
    assign corner = 1'b0;
`endif
    generate
        if (LINE_WIDTH == 800) begin : g_shift
            pixel_addr_calc u_addr (.x(sx[9:0]), .y(sy[9:0]), .addr(addr));
        end else begin : g_mul
            assign addr = 20'(32'(sy) * LINE_WIDTH + 32'(sx));
        end
    endgenerate
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= draw_pkg::IDLE;
            x             <= '0;
            y             <= '0;
            ps            <= '0;
            dx            <= '0;
            dy            <= '0;
            o_renew       <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_done  <= 1'b0;
            bus.o_wr_req  <= 1'b0;
            bus.o_wr_addr <= '0;
            bus.o_wr_data <= '0;
        end else begin
            case (state)
                draw_pkg::IDLE: if (start) begin
                    state  <= draw_pkg::LOAD;
                    o_busy <= 1'b1;
                end
                draw_pkg::LOAD: if (i_done) begin
                    state        <= draw_pkg::FIN;
                    o_frame_done <= 1'b1;
                end else begin
                    state         <= draw_pkg::STAMP;
                    x             <= i_X_pos;
                    y             <= i_Y_pos;
                    ps            <= point_size;
                    dx            <= '0;
                    dy            <= '0;
                    bus.o_wr_data <= color;
                    bus.o_wr_req  <= visible;
                    if (visible) bus.o_wr_addr <= addr;
                end
                draw_pkg::STAMP: if (advance) begin
                    if (last) begin
                        state        <= draw_pkg::RENEW;
                        bus.o_wr_req <= 1'b0;
                        o_renew      <= 1'b1;
                    end else begin
                        dx           <= ndx;
                        dy           <= ndy;
                        bus.o_wr_req <= visible;
                        if (visible) bus.o_wr_addr <= addr;
                    end
                end
                draw_pkg::RENEW: begin
                    state   <= draw_pkg::SETTLE;
                    o_renew <= 1'b0;
                end
                draw_pkg::SETTLE: state <= draw_pkg::LOAD;
                draw_pkg::FIN: begin
                    state        <= draw_pkg::IDLE;
                    o_frame_done <= 1'b0;
                    o_busy       <= 1'b0;
                end
                default: state <= draw_pkg::IDLE;
            endcase
        end
    end
endmodule

// File: doc/line_point_writer.md
LINE_POINT_WRITER -- requirements
Module: line_point_writer

Interface
REQ-001 Parameter X_MAX, default 10'd799, last visible column.
REQ-002 Parameter Y_MAX, default 10'd599, last visible row.
REQ-003 Parameter LINE_WIDTH, default 800, pixels per frame-buffer row.
REQ-004 The block SHALL have a single clock domain; reset is synchronous and active-low.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  synchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse, aligned with the line generator's end_frame; begins a line.
REQ-008 i_X_pos  in  10  current point column from the line generator.
REQ-009 i_Y_pos  in  10  current point row from the line generator.
REQ-010 i_done  in  1  line generator done flag; 1 = no further points.
REQ-011 point_size  in  4  stamp edge length minus 1; stamp is (point_size+1) x (point_size+1).
REQ-012 color  in  16  pixel value to write.
REQ-013 o_renew  out  1  one-cycle pulse requesting the next point; drives the generator's renew_output.
REQ-014 o_wr_req  out  1  frame-buffer write request.
REQ-015 o_wr_addr  out  20  pixel address.
REQ-016 o_wr_data  out  16  pixel data.
REQ-017 i_wr_ack  in  1  write accepted in this cycle.
REQ-018 o_busy  out  1  high from the cycle after start until the cycle o_frame_done pulses, inclusive.
REQ-019 o_frame_done  out  1  one-cycle pulse when the line is complete.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, STAMP, RENEW, SETTLE, and FIN.
REQ-021 IDLE: on start=1, go to LOAD next cycle; otherwise stay in IDLE.
REQ-022 LOAD: if i_done=1, go to FIN; otherwise latch i_X_pos, i_Y_pos, point_size, color, clear dx=dy=0, and go to STAMP.
REQ-023 STAMP: o_wr_req=1 with o_wr_addr=(Y+dy)*LINE_WIDTH+(X+dx) and o_wr_data=latched color.
REQ-024 STAMP: o_wr_req, o_wr_addr, and o_wr_data SHALL hold stable until i_wr_ack=1.
REQ-025 On ack, dx SHALL increment; at dx=point_size, dx SHALL wrap to 0 and dy SHALL increment; on ack of the final pixel, go to RENEW.
REQ-026 Clipping: a pixel with X+dx>X_MAX or Y+dy>Y_MAX SHALL NOT be requested and SHALL be skipped in 1 cycle with o_wr_req=0.
REQ-027 If the whole stamp is off-screen, STAMP SHALL still walk all positions, then go to RENEW.
REQ-028 Coordinate sums SHALL be computed at 11 bits so no wrap occurs; addresses SHALL stay below 480000.
REQ-029 RENEW: o_renew=1 for exactly one cycle, then go to SETTLE.
REQ-030 SETTLE: one idle cycle so the generator's registered position updates, then go to LOAD.
REQ-031 FIN: o_frame_done=1 for one cycle, then go to IDLE.
REQ-032 start while not in IDLE SHALL be ignored.
REQ-033 A point equal to the previous point SHALL still be stamped; duplicate writes are permitted.
REQ-034 Latency: first o_wr_req SHALL assert 2 cycles after start (start cycle, then LOAD).
REQ-035 A point with zero-wait ack SHALL take (point_size+1)^2+3 cycles from LOAD to the next LOAD.

Reset
REQ-036 When rst=0, all outputs SHALL be 0 and state SHALL be IDLE.
REQ-037 Reset SHALL clear dx, dy, and all latched coordinates to 0.
REQ-038 Reset mid-STAMP SHALL drop o_wr_req on the next edge; no o_renew or o_frame_done pulse SHALL be emitted.

Configuration
REQ-039 Macro POINT_ROUND_EN selects the stamp shape.
REQ-040 With POINT_ROUND_EN defined and point_size>=2, the 4 corner positions (dx,dy in {0,point_size}^2) SHALL be skipped like clipped pixels (1 cycle, no request).
REQ-041 Without POINT_ROUND_EN, the full square SHALL be written.

Structure
REQ-042 Shared package draw_pkg SHALL hold X_MAX, Y_MAX, LINE_WIDTH, the address width (20), and the FSM state enum.
REQ-043 Sub-module pixel_addr_calc (combinational) SHALL compute y*800+x as (y<<9)+(y<<8)+(y<<5)+x, with no multiplier.

Verification
REQ-044 point_size=0, color=16'hF800, single point (10,20), then i_done=1: exactly 1 write, addr 16010; o_renew once; o_frame_done 5 cycles after LOAD with ack tied high.
REQ-045 point_size=1, point (799,599): only addr 479999 written; 3 skipped cycles; o_renew then follows.
REQ-046 i_wr_ack held low 5 cycles on the first pixel of (0,0), point_size=1: addr/data stable for 6 cycles; total writes 0, 1, 800, 801.
REQ-047 POINT_ROUND_EN defined, point_size=2, point (100,100): 5 writes at addr 80101, 80900, 80901, 80902, 81701; without the macro: 9 writes.
REQ-048 Reset asserted during the 2nd pixel of a point_size=3 stamp: o_wr_req=0 the next cycle; no pulses; a fresh start then behaves normally.
REQ-049 start with i_done=1 already asserted: no writes, no o_renew; o_frame_done 2 cycles after start.
